// File: rtl/i2s_transmitter_pkg.sv
// Shared definitions for the I2S transmit path: default word widths and the
// channel encoding carried on lrclk (shared with the receive side).
package i2s_transmitter_pkg;

  localparam int unsigned DEF_FIFO_DATA_WIDTH    = 16;
  localparam int unsigned DEF_I2S_DATA_BIT_WIDTH = 24;

  // Word-select encoding: lrclk low carries the left channel, high the right.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // Channel owning a given frame position: the first slot_width bit clocks
  // of a frame are left, the rest are right.
  function automatic channel_e channel_of(input logic [15:0] bit_pos,
                                          input logic [15:0] slot_width);
    return (bit_pos >= slot_width) ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Write-side bus of the I2S transmitter: sample handshake plus FIFO status.
// The upstream writer is the master, the transmitter is the slave.
interface i2s_transmitter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEVEL_WIDTH = 7
);

  logic [DATA_WIDTH-1:0]  wdata;
  logic                   w_enable;
  logic                   w_ready;
  logic                   error_full;
  logic                   error_empty;
  logic [LEVEL_WIDTH-1:0] fifo_level;

  modport master (
    output wdata,
    output w_enable,
    input  w_ready,
    input  error_full,
    input  error_empty,
    input  fifo_level
  );

  modport slave (
    input  wdata,
    input  w_enable,
    output w_ready,
    output error_full,
    output error_empty,
    output fifo_level
  );

endinterface

// File: rtl/i2s_tx_fifo.sv
// Single-clock sample FIFO for the I2S transmitter. Pointers carry one extra
// wrap bit so full and empty are distinguishable; read data is combinational
// from the head entry. Writes while full and reads while empty are ignored.
module i2s_tx_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      w_enable,
  input  logic                      r_enable,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]           wptr_q, wptr_d;
  logic [AW:0]           rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push;
  logic                  pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign push  = w_enable && !full;
  assign pop   = r_enable && !empty;

  // Next pointer values and storage contents for the accepted push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d                = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  // Pointer registers; reset empties the FIFO by aligning both pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate access.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Single-lane I2S master transmitter. Buffers PCM words in a local FIFO,
// divides clk down to bclk, and shifts each word MSB-first into its channel
// slot one bclk after the lrclk edge. All pin outputs are registered and
// sdata/lrclk only move on bclk falls so the receiver samples on rises.
module i2s_transmitter
  import i2s_transmitter_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH      = DEF_FIFO_DATA_WIDTH,
  parameter int I2S_DATA_BIT_WIDTH   = DEF_I2S_DATA_BIT_WIDTH,
  parameter int SLOT_WIDTH           = 32,
  parameter int FIFO_DEPTH           = 64,
  parameter int BCLK_HALF            = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  i2s_transmitter_if.slave wr,
  output logic         bclk,
  output logic         lrclk,
  output logic         sdata
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W   = $clog2(BCLK_HALF);
  localparam int CNT_W   = $clog2(2 * SLOT_WIDTH);
  localparam int PAD_W   = I2S_DATA_BIT_WIDTH - FIFO_DATA_WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SLOT  = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_DBITS = CNT_W'(I2S_DATA_BIT_WIDTH);

  logic [DIV_W-1:0]              div_cnt_q, div_cnt_d;
  logic                          bclk_q, bclk_d;
  logic                          lrclk_q, lrclk_d;
  logic                          sdata_q, sdata_d;
  logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
  logic [I2S_DATA_BIT_WIDTH-1:0] sample_q, sample_d;
  logic                          error_full_q, error_full_d;
  logic                          error_empty_q, error_empty_d;

  logic                          div_term;
  logic                          fall;
  logic [CNT_W-1:0]              bit_cnt_next;
  logic [CNT_W-1:0]              slot_bit;
  logic [I2S_DATA_BIT_WIDTH-1:0] shifted;
  channel_e                      next_channel;

  logic [FIFO_DATA_WIDTH-1:0]    fifo_rdata;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_pop;
  logic [LEVEL_W-1:0]            fifo_level;
  logic                          unused_wdata_hi;

  assign unused_wdata_hi = ^wr.wdata[C_S_AXIS_TDATA_WIDTH-1:FIFO_DATA_WIDTH];

  i2s_tx_fifo #(
    .DATA_WIDTH (FIFO_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wdata    (wr.wdata[FIFO_DATA_WIDTH-1:0]),
    .w_enable (wr.w_enable && !fifo_full),
    .r_enable (fifo_pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign div_term = (div_cnt_q == DIV_LAST);
  assign fall     = div_term && bclk_q;

  // Free-running bclk divider: toggle bclk each time div_cnt reaches its top.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_ONE;
    bclk_d    = bclk_q;
    if (div_term) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
  end

  // Frame position, channel select, slot-start pop and serial bit on each fall.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    sample_d      = sample_q;
    error_empty_d = error_empty_q;
    error_full_d  = error_full_q | (wr.w_enable && fifo_full);
    fifo_pop      = 1'b0;

    bit_cnt_next  = (bit_cnt_q == CNT_LAST) ? '0 : (bit_cnt_q + CNT_ONE);
    next_channel  = channel_of(16'(bit_cnt_next), 16'(SLOT_WIDTH));
    slot_bit      = (next_channel == CH_RIGHT) ? (bit_cnt_next - CNT_SLOT) : bit_cnt_next;
    shifted       = sample_q >> (CNT_DBITS - slot_bit);

    if (fall) begin
      bit_cnt_d = bit_cnt_next;
      lrclk_d   = next_channel;
      if (slot_bit == '0) begin
        if (fifo_empty) begin
          sample_d      = '0;
          error_empty_d = 1'b1;
        end else begin
          sample_d = {fifo_rdata, {PAD_W{1'b0}}};
          fifo_pop = 1'b1;
        end
      end
      if ((slot_bit >= CNT_ONE) && (slot_bit <= CNT_DBITS)) begin
        sdata_d = shifted[0];
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  // State registers; reset parks the frame counter so the first fall opens the left slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      bit_cnt_q     <= CNT_LAST;
      sample_q      <= '0;
      error_full_q  <= 1'b0;
      error_empty_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      bit_cnt_q     <= bit_cnt_d;
      sample_q      <= sample_d;
      error_full_q  <= error_full_d;
      error_empty_q <= error_empty_d;
    end
  end

  assign bclk           = bclk_q;
  assign lrclk          = lrclk_q;
  assign sdata          = sdata_q;
  assign wr.w_ready     = ~fifo_full;
  assign wr.error_full  = error_full_q;
  assign wr.error_empty = error_empty_q;
  assign wr.fifo_level  = fifo_level;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter. Instance A runs a fast bclk (BCLK_HALF=2) for
// framing, serial data and mid-frame reset; instance B runs BCLK_HALF=64 so
// the FIFO can be filled before the first slot starts.
module tb_i2s_transmitter;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  logic bclk_a, lrclk_a, sdata_a;
  logic bclk_b, lrclk_b, sdata_b;

  int n_checks;
  int n_fail;

  i2s_transmitter_if #(.DATA_WIDTH(32), .LEVEL_WIDTH(7)) if_a ();
  i2s_transmitter_if #(.DATA_WIDTH(32), .LEVEL_WIDTH(7)) if_b ();

  i2s_transmitter #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .FIFO_DATA_WIDTH      (16),
    .I2S_DATA_BIT_WIDTH   (24),
    .SLOT_WIDTH           (32),
    .FIFO_DEPTH           (64),
    .BCLK_HALF            (2)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .wr    (if_a),
    .bclk  (bclk_a),
    .lrclk (lrclk_a),
    .sdata (sdata_a)
  );

  i2s_transmitter #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .FIFO_DATA_WIDTH      (16),
    .I2S_DATA_BIT_WIDTH   (24),
    .SLOT_WIDTH           (32),
    .FIFO_DEPTH           (64),
    .BCLK_HALF            (64)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .wr    (if_b),
    .bclk  (bclk_b),
    .lrclk (lrclk_b),
    .sdata (sdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] left_word;
    logic [15:0] right_word;
    logic [31:0] exp_left;
    logic [31:0] exp_right;
  } vec_t;

  vec_t vecs [4];

  // Compare one observed value against its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Push one word into the selected instance on the next clk edge.
  task automatic applyStimulus(input int inst, input logic [31:0] word);
    if (inst == 0) begin
      if_a.wdata = word; if_a.w_enable = 1'b1;
    end else begin
      if_b.wdata = word; if_b.w_enable = 1'b1;
    end
    @(negedge clk);
    if_a.w_enable = 1'b0;
    if_b.w_enable = 1'b0;
  endtask

  // Hold reset for three clocks, optionally check the reset state, then release.
  task automatic resetDut(input int inst, input bit do_check);
    if_a.w_enable = 1'b0;
    if_b.w_enable = 1'b0;
    if (inst == 0) rst_n_a = 1'b0; else rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    if (do_check) begin
      if (inst == 0) begin
        checkOutput("rst_a_pins", {bclk_a, lrclk_a, sdata_a}, 3'b000);
        checkOutput("rst_a_flags", {if_a.error_full, if_a.error_empty, if_a.w_ready}, 3'b001);
        checkOutput("rst_a_level", 64'(if_a.fifo_level), 64'd0);
      end else begin
        checkOutput("rst_b_pins", {bclk_b, lrclk_b, sdata_b}, 3'b000);
        checkOutput("rst_b_flags", {if_b.error_full, if_b.error_empty, if_b.w_ready}, 3'b001);
      end
    end
    if (inst == 0) rst_n_a = 1'b1; else rst_n_b = 1'b1;
  endtask

  // Step clk until the selected bclk falls; an expired budget counts as a failure.
  task automatic waitFall(input int inst, output logic sd, output logic lr);
    logic prev, cur;
    bit   found;
    int   budget;
    prev   = (inst == 0) ? bclk_a : bclk_b;
    found  = 1'b0;
    budget = 0;
    sd     = 1'b0;
    lr     = 1'b0;
    while (!found && budget < 300) begin
      @(negedge clk);
      budget++;
      cur = (inst == 0) ? bclk_a : bclk_b;
      if (prev && !cur) begin
        found = 1'b1;
        sd    = (inst == 0) ? sdata_a : sdata_b;
        lr    = (inst == 0) ? lrclk_a : lrclk_b;
      end
      prev = cur;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL bclk_fall_timeout: no fall within %0d clocks, expected one", budget);
    end
  endtask

  // Capture sdata and lrclk on the next n falls; bit i holds fall i.
  task automatic captureFalls(input int inst, input int n,
                              output logic [95:0] sd_bits, output logic [95:0] lr_bits);
    logic sd, lr;
    sd_bits = '0;
    lr_bits = '0;
    for (int i = 0; i < n; i++) begin
      waitFall(inst, sd, lr);
      sd_bits[i] = sd;
      lr_bits[i] = lr;
    end
  endtask

  // Pack one 32-bit slot so slot bit b0 lands in the MSB.
  function automatic logic [31:0] slotWord(input logic [95:0] bits, input int base);
    logic [31:0] r;
    for (int j = 0; j < 32; j++) r[31-j] = bits[base+j];
    return r;
  endfunction

  initial begin
    logic [95:0] sd_bits, lr_bits;
    logic [3:0]  bclk_seq;
    logic        sd, lr;

    n_checks = 0;
    n_fail   = 0;
    rst_n_a  = 1'b0;
    rst_n_b  = 1'b0;
    if_a.wdata = '0; if_a.w_enable = 1'b0;
    if_b.wdata = '0; if_b.w_enable = 1'b0;

    vecs[0] = '{16'hA5A5, 16'h0F0F, 32'h52D2_8000, 32'h0787_8000};
    vecs[1] = '{16'hFFFF, 16'h0001, 32'h7FFF_8000, 32'h0000_8000};
    vecs[2] = '{16'h8000, 16'h0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{16'h1234, 16'h5678, 32'h091A_0000, 32'h2B3C_0000};

    @(negedge clk);

    $display("[TB] bclk timing and underrun with no writes");
    resetDut(0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bclk_seq[k] = bclk_a;
    end
    checkOutput("bclk_first_period", 64'(bclk_seq), 64'b0110);
    checkOutput("underrun_after_first_fall", 64'(if_a.error_empty), 64'd1);
    sd_bits = '0;
    lr_bits = '0;
    sd_bits[0] = sdata_a;
    lr_bits[0] = lrclk_a;
    for (int i = 1; i < 64; i++) begin
      waitFall(0, sd, lr);
      sd_bits[i] = sd;
      lr_bits[i] = lr;
    end
    checkOutput("lrclk_frame_idle", lr_bits[63:0], {32'hFFFF_FFFF, 32'h0000_0000});
    checkOutput("sdata_idle", sd_bits[63:0], 64'd0);
    checkOutput("underrun_sticky", 64'(if_a.error_empty), 64'd1);
    checkOutput("no_overflow_idle", 64'(if_a.error_full), 64'd0);

    $display("[TB] frame vectors");
    for (int v = 0; v < 4; v++) begin
      resetDut(0, 1'b0);
      applyStimulus(0, {16'h0000, vecs[v].left_word});
      applyStimulus(0, {16'h0000, vecs[v].right_word});
      checkOutput($sformatf("v%0d_level", v), 64'(if_a.fifo_level), 64'd2);
      captureFalls(0, 64, sd_bits, lr_bits);
      checkOutput($sformatf("v%0d_left_slot", v), 64'(slotWord(sd_bits, 0)), 64'(vecs[v].exp_left));
      checkOutput($sformatf("v%0d_right_slot", v), 64'(slotWord(sd_bits, 32)), 64'(vecs[v].exp_right));
      checkOutput($sformatf("v%0d_lrclk", v), lr_bits[63:0], {32'hFFFF_FFFF, 32'h0000_0000});
      checkOutput($sformatf("v%0d_no_underrun", v), 64'(if_a.error_empty), 64'd0);
    end

    $display("[TB] mid-frame reset in right slot");
    resetDut(0, 1'b0);
    applyStimulus(0, 32'h0000_3C3C);
    for (int f = 1; f <= 107; f++) begin
      waitFall(0, sd, lr);
      if (f == 33) checkOutput("underrun_right_slot", 64'(if_a.error_empty), 64'd1);
      if (f == 40) begin
        applyStimulus(0, 32'h0000_FFFF);
        applyStimulus(0, 32'h0000_FFFF);
      end
      if (f == 100) applyStimulus(0, 32'h0000_1111);
    end
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_pins", {bclk_a, lrclk_a, sdata_a}, 3'b111);
    checkOutput("pre_reset_level", 64'(if_a.fifo_level), 64'd1);
    rst_n_a = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_pins", {bclk_a, lrclk_a, sdata_a}, 3'b000);
    checkOutput("mid_reset_flags", {if_a.error_full, if_a.error_empty, if_a.w_ready}, 3'b001);
    checkOutput("mid_reset_level", 64'(if_a.fifo_level), 64'd0);
    @(negedge clk);
    rst_n_a = 1'b1;
    applyStimulus(0, 32'h0000_1234);
    applyStimulus(0, 32'h0000_5678);
    captureFalls(0, 64, sd_bits, lr_bits);
    checkOutput("post_reset_left", 64'(slotWord(sd_bits, 0)), 64'h091A_0000);
    checkOutput("post_reset_right", 64'(slotWord(sd_bits, 32)), 64'h2B3C_0000);
    checkOutput("post_reset_lrclk", lr_bits[63:0], {32'hFFFF_FFFF, 32'h0000_0000});

    $display("[TB] full FIFO with push coincident with pop");
    resetDut(1, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      if_b.wdata    = 32'h0000_B000 + 32'(k);
      if_b.w_enable = 1'b1;
      @(negedge clk);
    end
    if_b.w_enable = 1'b0;
    checkOutput("fill_level", 64'(if_b.fifo_level), 64'd64);
    checkOutput("fill_ready_flag", {if_b.w_ready, if_b.error_full}, 2'b00);
    repeat (63) @(negedge clk);
    checkOutput("bclk_before_first_fall", 64'(bclk_b), 64'd1);
    if_b.wdata    = 32'h0000_DEAD;
    if_b.w_enable = 1'b1;
    @(negedge clk);
    if_b.w_enable = 1'b0;
    checkOutput("coincident_fall", 64'(bclk_b), 64'd0);
    checkOutput("coincident_level", 64'(if_b.fifo_level), 64'd63);
    checkOutput("coincident_flags", {if_b.error_full, if_b.w_ready}, 2'b11);

    $display("[TB] overfill and pop order");
    resetDut(1, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      if_b.wdata    = 32'hABCD_C000 + 32'(k - 1);
      if_b.w_enable = 1'b1;
      @(negedge clk);
      if (k == 63) checkOutput("ready_at_63", 64'(if_b.w_ready), 64'd1);
      if (k == 64) checkOutput("ready_flag_at_64", {if_b.w_ready, if_b.error_full}, 2'b00);
      if (k == 65) checkOutput("overflow_at_65", 64'(if_b.error_full), 64'd1);
    end
    if_b.w_enable = 1'b0;
    checkOutput("overfill_level", 64'(if_b.fifo_level), 64'd64);
    captureFalls(1, 96, sd_bits, lr_bits);
    checkOutput("pop0_left", 64'(slotWord(sd_bits, 0)), 64'h6000_0000);
    checkOutput("pop1_right", 64'(slotWord(sd_bits, 32)), 64'h6000_8000);
    checkOutput("pop2_left", 64'(slotWord(sd_bits, 64)), 64'h6001_0000);
    checkOutput("overflow_sticky", 64'(if_b.error_full), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
